// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: data accesses have strict priority over instruction
// fetches, at most one bus transaction is in flight, and a bounded wait counter turns a
// missing acknowledge into a one-cycle error pulse plus a zero-data completion.
module mem_arbiter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,

  // Instruction fetch port
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ready_o,

  // Data port
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,

  // Shared memory bus
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,

  output logic        stall_o,
  output logic        bus_err_o
);

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StDataWait,
    StInstWait
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        bus_err_q, bus_err_d;

  logic        mem_pend, if_pend;
  logic        mem_set, if_set;

  assign mem_pend = mem_ce_i & ~mem_done_q;
  assign if_pend  = if_ce_i & ~if_done_q;
  assign stall_o  = mem_pend | if_pend;

  // Next-state logic: grant, completion, timeout and done-flag bookkeeping
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = 1'b0;
    mem_set     = 1'b0;
    if_set      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Ack strobes arriving here belong to no transaction and are dropped.
        if (mem_pend) begin
          state_d     = StDataWait;
          cnt_d       = 8'd0;
          bus_req_d   = 1'b1;
          bus_addr_d  = mem_addr_i;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_wdata_d = mem_data_i;
        end else if (if_pend) begin
          state_d     = StInstWait;
          cnt_d       = 8'd0;
          bus_req_d   = 1'b1;
          bus_addr_d  = if_addr_i;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'b1111;
          bus_wdata_d = 32'h0;
        end else begin
          bus_req_d = 1'b0;
        end
      end

      StDataWait: begin
        if (bus_ack_i) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          mem_set   = 1'b1;
          // Stores leave the load-data register untouched.
          if (!bus_we_q) mem_data_d = bus_rdata_i;
        end else if (cnt_q == WaitMax) begin
          state_d    = StIdle;
          bus_req_d  = 1'b0;
          bus_err_d  = 1'b1;
          mem_set    = 1'b1;
          mem_data_d = 32'h0;
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StInstWait: begin
        if (bus_ack_i) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          if_set    = 1'b1;
          if_data_d = bus_rdata_i;
        end else if (cnt_q == WaitMax) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if_set    = 1'b1;
          if_data_d = 32'h0;
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = StIdle;
        bus_req_d = 1'b0;
      end
    endcase

    // Done flags hold until the pipeline advances (stall low); a same-edge set wins.
    if (mem_set)       mem_done_d = 1'b1;
    else if (!stall_o) mem_done_d = 1'b0;
    else               mem_done_d = mem_done_q;

    if (if_set)        if_done_d = 1'b1;
    else if (!stall_o) if_done_d = 1'b0;
    else               if_done_d = if_done_q;
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'h0;
      mem_data_q  <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'h0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign if_data_o   = if_data_q;
  assign if_ready_o  = if_done_q;
  assign mem_data_o  = mem_data_q;
  assign mem_ready_o = mem_done_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_err_o   = bus_err_q;

endmodule
